roic_line_sequencer: RTL and testbench

ROIC_LINE_SEQUENCER -- requirements
Module: roic_line_sequencer

---
 rtl/roic_line_sequencer_if.sv | 25 ++
 rtl/roic_line_sequencer.sv | 113 +++++++++++
 tb/tb_roic_line_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/roic_line_sequencer_if.sv
// Detector-to-sequencer stream and readout results for the ROIC line sequencer.
// The sequencer takes the slave view; whoever feeds it takes the master view.
interface roic_line_sequencer_if;
    logic        capture_en;
    logic        word_valid;
    logic [23:0] word_data;
    logic        first_sample_pulse;
    logic        ch_valid;
    logic [15:0] ch_data;
    logic [9:0]  ch_index;
    logic        line_done;
    logic [15:0] line_count;
    logic        sync_err;
    logic [1:0]  seq_state;

    modport master (
        output capture_en, word_valid, word_data, first_sample_pulse,
        input  ch_valid, ch_data, ch_index, line_done, line_count, sync_err, seq_state
    );

    modport slave (
        input  capture_en, word_valid, word_data, first_sample_pulse,
        output ch_valid, ch_data, ch_index, line_done, line_count, sync_err, seq_state
    );
endinterface

// File: rtl/roic_line_sequencer.sv
// Splits the aligned detector word stream into per-channel samples, one readout line at a time,
// with line-sync tracking, sync timeout and mid-line resync.
//
//  state     | meaning
//  IDLE      | capture disabled, waiting for capture_en
//  WAIT_SYNC | armed, waiting for first_sample_pulse; timeout counter running
//  CAPTURE   | accepting words as channels 0..NUM_CH-1
//  DONE      | one-cycle gap after the last channel of a line
module roic_line_sequencer #(
    parameter int NUM_CH       = 256,
    parameter int SYNC_TIMEOUT = 4096
) (
    input logic                    clk,
    input logic                    rst_n,
    roic_line_sequencer_if.slave   bus
);
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_SYNC = 2'd1;
    localparam logic [1:0] ST_CAPTURE   = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    localparam logic [9:0]  LAST_CH = 10'(NUM_CH - 1);
    localparam logic [15:0] TO_LAST = 16'(SYNC_TIMEOUT - 1);

    logic [1:0]  state;
    logic [9:0]  ch_cnt;
    logic [15:0] to_cnt;
    logic        ch_valid_q;
    logic [15:0] ch_data_q;
    logic [9:0]  ch_index_q;
    logic        line_done_q;
    logic [15:0] line_count_q;
    logic        sync_err_q;
    logic        accept_last;
    logic        unused_word_lsb;

    // Low byte of the aligned word carries no sample information.
    assign unused_word_lsb = ^bus.word_data[7:0];

    assign accept_last = bus.word_valid && (ch_cnt == LAST_CH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            ch_cnt       <= '0;
            to_cnt       <= '0;
            ch_valid_q   <= 1'b0;
            ch_data_q    <= '0;
            ch_index_q   <= '0;
            line_done_q  <= 1'b0;
            line_count_q <= '0;
            sync_err_q   <= 1'b0;
        end else begin
            ch_valid_q  <= 1'b0;
            line_done_q <= 1'b0;
            sync_err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    to_cnt <= '0;
                    if (bus.capture_en) state <= ST_WAIT_SYNC;
                end
                ST_WAIT_SYNC: begin
                    if (bus.first_sample_pulse) begin
                        state  <= ST_CAPTURE;
                        ch_cnt <= '0;
                        to_cnt <= '0;
                    end else if (!bus.capture_en) begin
                        state  <= ST_IDLE;
                        to_cnt <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        sync_err_q <= 1'b1;
                        to_cnt     <= '0;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                ST_CAPTURE: begin
                    to_cnt <= '0;
                    // A sync coinciding with the last channel is the next line starting on time.
                    if (accept_last) begin
                        ch_valid_q   <= 1'b1;
                        ch_data_q    <= bus.word_data[23:8];
                        ch_index_q   <= ch_cnt;
                        line_done_q  <= 1'b1;
                        line_count_q <= line_count_q + 16'd1;
                        ch_cnt       <= '0;
                        if (!(bus.first_sample_pulse && bus.capture_en)) state <= ST_DONE;
                    end else if (bus.first_sample_pulse) begin
                        sync_err_q <= 1'b1;
                        ch_cnt     <= '0;
                    end else if (bus.word_valid) begin
                        ch_valid_q <= 1'b1;
                        ch_data_q  <= bus.word_data[23:8];
                        ch_index_q <= ch_cnt;
                        ch_cnt     <= ch_cnt + 10'd1;
                    end
                end
                default: begin
                    to_cnt <= '0;
                    state  <= bus.capture_en ? ST_WAIT_SYNC : ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ch_valid   = ch_valid_q;
    assign bus.ch_data    = ch_data_q;
    assign bus.ch_index   = ch_index_q;
    assign bus.line_done  = line_done_q;
    assign bus.line_count = line_count_q;
    assign bus.sync_err   = sync_err_q;
    assign bus.seq_state  = state;
endmodule

// File: tb/tb_roic_line_sequencer.sv
// Directed bench for roic_line_sequencer with NUM_CH=8 and SYNC_TIMEOUT=16.
module tb_roic_line_sequencer;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   exp_lines;

    roic_line_sequencer_if bus ();

    roic_line_sequencer #(.NUM_CH(8), .SYNC_TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic word(input int idx, input bit last);
        logic [23:0] d;
        logic [7:0]  b;
        b = 8'(idx);
        d = {8'(idx * 17 + 3), b ^ 8'hA5, b};
        bus.word_valid = 1'b1;
        bus.word_data  = d;
        tick();
        bus.word_valid = 1'b0;
        if (last) exp_lines++;
        chk("ch_valid", 32'(bus.ch_valid), 32'd1);
        chk("ch_index", 32'(bus.ch_index), 32'(idx));
        chk("ch_data", 32'(bus.ch_data), 32'(d[23:8]));
        chk("line_done", 32'(bus.line_done), 32'(last));
        chk("line_count", 32'(bus.line_count), 32'(exp_lines));
        chk("no_sync_err", 32'(bus.sync_err), 32'd0);
    endtask

    task automatic sync_into_capture();
        bus.first_sample_pulse = 1'b1;
        tick();
        bus.first_sample_pulse = 1'b0;
        chk("enter_capture", 32'(bus.seq_state), 32'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int err_cnt;
        int first_err;
        int second_err;
        int state_bad;

        total = 0;
        bad = 0;
        exp_lines = 0;
        rst_n = 1'b0;
        bus.capture_en = 1'b0;
        bus.word_valid = 1'b0;
        bus.word_data = '0;
        bus.first_sample_pulse = 1'b0;
        tick();
        tick();
        chk("rst_state", 32'(bus.seq_state), 32'd0);
        chk("rst_ch_valid", 32'(bus.ch_valid), 32'd0);
        chk("rst_line_count", 32'(bus.line_count), 32'd0);
        chk("rst_sync_err", 32'(bus.sync_err), 32'd0);
        chk("rst_line_done", 32'(bus.line_done), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_hold", 32'(bus.seq_state), 32'd0);

        // basic line of 8 back-to-back words
        bus.capture_en = 1'b1;
        tick();
        chk("to_wait_sync", 32'(bus.seq_state), 32'd1);
        sync_into_capture();
        for (int i = 0; i < 8; i++) word(i, i == 7);
        chk("done_state", 32'(bus.seq_state), 32'd3);
        bus.first_sample_pulse = 1'b1;
        tick();
        bus.first_sample_pulse = 1'b0;
        chk("done_to_wait", 32'(bus.seq_state), 32'd1);
        chk("done_sync_ignored", 32'(bus.sync_err), 32'd0);
        chk("done_no_ch_valid", 32'(bus.ch_valid), 32'd0);

        // gapped words
        sync_into_capture();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("gap_no_ch_valid", 32'(bus.ch_valid), 32'd0);
            word(i, i == 7);
        end
        tick();
        chk("gap_line_back_to_wait", 32'(bus.seq_state), 32'd1);

        // mid-line resync
        sync_into_capture();
        for (int i = 0; i < 3; i++) word(i, 1'b0);
        bus.first_sample_pulse = 1'b1;
        tick();
        bus.first_sample_pulse = 1'b0;
        chk("resync_err", 32'(bus.sync_err), 32'd1);
        chk("resync_state", 32'(bus.seq_state), 32'd2);
        chk("resync_line_count", 32'(bus.line_count), 32'(exp_lines));
        tick();
        chk("resync_err_single", 32'(bus.sync_err), 32'd0);
        for (int i = 0; i < 8; i++) word(i, i == 7);
        tick();
        chk("resync_back_to_wait", 32'(bus.seq_state), 32'd1);

        // sync timeout, just entered WAIT_SYNC
        err_cnt = 0;
        first_err = -1;
        second_err = -1;
        state_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus.seq_state !== 2'd1) state_bad++;
            if (bus.sync_err === 1'b1) begin
                err_cnt++;
                if (first_err < 0) first_err = k;
                else if (second_err < 0) second_err = k;
            end
        end
        chk("timeout_count", 32'(err_cnt), 32'd2);
        chk("timeout_first", 32'(first_err), 32'd16);
        chk("timeout_spacing", 32'(second_err - first_err), 32'd16);
        chk("timeout_state", 32'(state_bad), 32'd0);

        // sync on the last channel: next line starts with no DONE
        sync_into_capture();
        for (int i = 0; i < 7; i++) word(i, 1'b0);
        bus.first_sample_pulse = 1'b1;
        word(7, 1'b1);
        bus.first_sample_pulse = 1'b0;
        chk("sync_on_last_state", 32'(bus.seq_state), 32'd2);
        tick();
        chk("sync_on_last_no_err", 32'(bus.sync_err), 32'd0);
        chk("sync_on_last_still_capture", 32'(bus.seq_state), 32'd2);
        for (int i = 0; i < 8; i++) word(i, i == 7);
        chk("second_line_done_state", 32'(bus.seq_state), 32'd3);
        tick();

        // capture_en dropped at channel 2: line completes, then IDLE
        sync_into_capture();
        word(0, 1'b0);
        word(1, 1'b0);
        bus.capture_en = 1'b0;
        for (int i = 2; i < 8; i++) word(i, i == 7);
        chk("drop_en_done", 32'(bus.seq_state), 32'd3);
        tick();
        chk("drop_en_idle", 32'(bus.seq_state), 32'd0);
        bus.first_sample_pulse = 1'b1;
        tick();
        bus.first_sample_pulse = 1'b0;
        chk("idle_sync_ignored_state", 32'(bus.seq_state), 32'd0);
        chk("idle_sync_ignored_err", 32'(bus.sync_err), 32'd0);

        // reset at channel 4
        bus.capture_en = 1'b1;
        tick();
        sync_into_capture();
        for (int i = 0; i < 4; i++) word(i, 1'b0);
        rst_n = 1'b0;
        bus.word_valid = 1'b1;
        bus.word_data = 24'hFEDCBA;
        tick();
        bus.word_valid = 1'b0;
        exp_lines = 0;
        chk("mid_rst_ch_valid", 32'(bus.ch_valid), 32'd0);
        chk("mid_rst_line_done", 32'(bus.line_done), 32'd0);
        chk("mid_rst_sync_err", 32'(bus.sync_err), 32'd0);
        chk("mid_rst_line_count", 32'(bus.line_count), 32'd0);
        chk("mid_rst_ch_data", 32'(bus.ch_data), 32'd0);
        chk("mid_rst_ch_index", 32'(bus.ch_index), 32'd0);
        chk("mid_rst_state", 32'(bus.seq_state), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_resume", 32'(bus.seq_state), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
